// File: rtl/noc_router_pkg.sv
// Shared helpers for the credit-based NoC router crossbar.
package noc_router_pkg;

  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction

  // Callers pass a one-hot (or zero) vector; OR-ing the set indices yields its position.
  function automatic int unsigned oh_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (oh[k]) idx = idx | k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter with mask-based rotating priority; pointer moves past the grant on enable.
module noc_rr_arbiter
  import noc_router_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [N-1:0]  mask;
  logic [N-1:0]  masked;
  logic [N-1:0]  pick;

  always_comb begin
    mask   = {N{1'b1}} << ptr;
    masked = req & mask;
    pick   = (|masked) ? masked : req;
    grant  = pick & (~pick + N'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (enable && (|grant)) begin
      ptr <= PW'((oh_to_idx(32'(grant)) + 1) % N);
    end
  end

endmodule

// File: rtl/noc_router_xbar_credit.sv
// Credit-based wormhole crossbar: per-(output,VC) packet locking, per-output VC interleave,
// registered output stage gated by downstream credit counters.
module noc_router_xbar_credit
  import noc_router_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int VCHANNELS  = 2,
  parameter int INPUTS     = 5,
  parameter int OUTPUTS    = 5,
  parameter int CREDITS    = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [INPUTS-1:0][FLIT_WIDTH-1:0]              in_flit,
  input  logic [INPUTS-1:0]                              in_last,
  input  logic [INPUTS-1:0][VCHANNELS-1:0][OUTPUTS-1:0]  in_valid,
  output logic [INPUTS-1:0][VCHANNELS-1:0][OUTPUTS-1:0]  in_ready,
  output logic [OUTPUTS-1:0][FLIT_WIDTH-1:0]             out_flit,
  output logic [OUTPUTS-1:0]                             out_last,
  output logic [OUTPUTS-1:0][VCHANNELS-1:0]              out_valid,
  input  logic [OUTPUTS-1:0][VCHANNELS-1:0]              out_credit
);

  localparam int IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int VW = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;
  localparam int CW = credit_width(CREDITS);

  logic [OUTPUTS-1:0][VCHANNELS-1:0][INPUTS-1:0] arb_req;
  logic [OUTPUTS-1:0][VCHANNELS-1:0][INPUTS-1:0] in_gnt;
  logic [OUTPUTS-1:0][VCHANNELS-1:0][IW-1:0]     sel_idx;
  logic [OUTPUTS-1:0][VCHANNELS-1:0][IW-1:0]     lock_idx;
  logic [OUTPUTS-1:0][VCHANNELS-1:0][CW-1:0]     credit;
  logic [OUTPUTS-1:0][VCHANNELS-1:0]             lock_vld;
  logic [OUTPUTS-1:0][VCHANNELS-1:0]             vc_req;
  logic [OUTPUTS-1:0][VCHANNELS-1:0]             vc_gnt;
  logic [OUTPUTS-1:0][VCHANNELS-1:0]             xfer;
  logic [OUTPUTS-1:0][VCHANNELS-1:0]             in_arb_en;
  logic [OUTPUTS-1:0][VW-1:0]                    out_vc;
  logic [OUTPUTS-1:0][IW-1:0]                    out_src;

  // A locked (o,v) only lets its holder request, so a stalled holder still blocks the channel.
  always_comb begin
    arb_req = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      for (int v = 0; v < VCHANNELS; v++) begin
        for (int i = 0; i < INPUTS; i++) begin
          arb_req[o][v][i] = in_valid[i][v][o] &&
                             (!lock_vld[o][v] || (lock_idx[o][v] == IW'(i)));
        end
      end
    end
  end

  always_comb begin
    sel_idx = '0;
    vc_req  = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      for (int v = 0; v < VCHANNELS; v++) begin
        sel_idx[o][v] = IW'(oh_to_idx(32'(in_gnt[o][v])));
        vc_req[o][v]  = (|in_gnt[o][v]) && (credit[o][v] != '0);
      end
    end
  end

  always_comb begin
    xfer      = '0;
    in_arb_en = '0;
    in_ready  = '0;
    out_vc    = '0;
    out_src   = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      out_vc[o]  = VW'(oh_to_idx(32'(vc_gnt[o])));
      out_src[o] = sel_idx[o][out_vc[o]];
      for (int v = 0; v < VCHANNELS; v++) begin
        xfer[o][v]      = rst && vc_gnt[o][v];
        in_arb_en[o][v] = xfer[o][v] && in_last[sel_idx[o][v]];
        for (int i = 0; i < INPUTS; i++) begin
          in_ready[i][v][o] = xfer[o][v] && in_gnt[o][v][i];
        end
      end
    end
  end

  for (genvar o = 0; o < OUTPUTS; o++) begin : g_out
    for (genvar v = 0; v < VCHANNELS; v++) begin : g_vc
      noc_rr_arbiter #(.N(INPUTS)) u_in_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req[o][v]),
        .enable (in_arb_en[o][v]),
        .grant  (in_gnt[o][v])
      );
    end
    noc_rr_arbiter #(.N(VCHANNELS)) u_vc_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (vc_req[o]),
      .enable (|xfer[o]),
      .grant  (vc_gnt[o])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_flit  <= '0;
      out_last  <= '0;
      out_valid <= '0;
      lock_vld  <= '0;
      lock_idx  <= '0;
      credit    <= {(OUTPUTS * VCHANNELS){CW'(CREDITS)}};
    end else begin
      for (int o = 0; o < OUTPUTS; o++) begin
        out_valid[o] <= xfer[o];
        out_last[o]  <= (|xfer[o]) && in_last[out_src[o]];
        if (|xfer[o]) out_flit[o] <= in_flit[out_src[o]];
        for (int v = 0; v < VCHANNELS; v++) begin
          if (xfer[o][v]) begin
            lock_vld[o][v] <= !in_last[sel_idx[o][v]];
            lock_idx[o][v] <= sel_idx[o][v];
          end
          if (xfer[o][v] && !out_credit[o][v]) begin
            credit[o][v] <= credit[o][v] - CW'(1);
          end else if (!xfer[o][v] && out_credit[o][v] && (credit[o][v] != CW'(CREDITS))) begin
            credit[o][v] <= credit[o][v] + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_router_xbar_credit.sv
// Directed bench for the credit-based crossbar: locking, fairness, credits, VC interleave, reset.
module tb_noc_router_xbar_credit;

  localparam int FW = 32;
  localparam int VC = 2;
  localparam int NI = 5;
  localparam int NO = 5;
  localparam int CR = 4;

  logic                          clk;
  logic                          rst;
  logic [NI-1:0][FW-1:0]         in_flit;
  logic [NI-1:0]                 in_last;
  logic [NI-1:0][VC-1:0][NO-1:0] in_valid;
  logic [NI-1:0][VC-1:0][NO-1:0] in_ready;
  logic [NO-1:0][FW-1:0]         out_flit;
  logic [NO-1:0]                 out_last;
  logic [NO-1:0][VC-1:0]         out_valid;
  logic [NO-1:0][VC-1:0]         out_credit;

  int          n_err;
  int          n_chk;
  int          a;
  int          b;
  logic [31:0] pf;
  logic        pl;
  logic        p0;

  noc_router_xbar_credit #(
    .FLIT_WIDTH (FW),
    .VCHANNELS  (VC),
    .INPUTS     (NI),
    .OUTPUTS    (NO),
    .CREDITS    (CR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit    (in_flit),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_flit   (out_flit),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_credit (out_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    in_flit    = '0;
    in_last    = '0;
    in_valid   = '0;
    out_credit = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;

    // reset state
    reset_dut();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_last", 32'(out_last), 32'h0);
    chk("rst_credit", 32'(dut.credit[2][1]), 32'(CR));
    @(posedge clk);
    #1;

    // single-flit packet, input 0 -> output 1 VC0
    in_valid[0][0][1] = 1'b1;
    in_last[0]        = 1'b1;
    in_flit[0]        = 32'hA5A5_0001;
    @(negedge clk);
    chk("s1_ready", 32'(in_ready[0][0][1]), 32'h1);
    @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    chk("s1_out_valid", 32'(out_valid[1]), 32'h1);
    chk("s1_out_flit", out_flit[1], 32'hA5A5_0001);
    chk("s1_out_last", 32'(out_last[1]), 32'h1);
    chk("s1_credit", 32'(dut.credit[1][0]), 32'h3);
    chk("s1_no_lock", 32'(dut.lock_vld[1][0]), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("s1_one_cycle", 32'(out_valid[1]), 32'h0);

    // contention: inputs 0 and 2, 3-flit packets to output 3 VC1
    reset_dut();
    a = 0;
    b = 0;
    pf = '0;
    pl = 1'b0;
    for (int c = 0; c < 7; c++) begin
      clear_inputs();
      out_credit[3][1] = 1'b1;
      if (a < 3) begin
        in_valid[0][1][3] = 1'b1;
        in_flit[0]        = 32'h10 + a;
        in_last[0]        = (a == 2);
      end
      if (b < 3) begin
        in_valid[2][1][3] = 1'b1;
        in_flit[2]        = 32'h20 + b;
        in_last[2]        = (b == 2);
      end
      @(negedge clk);
      chk("s2_ready_in0", 32'(in_ready[0][1][3]), 32'(c < 3));
      chk("s2_ready_in2", 32'(in_ready[2][1][3]), 32'(c >= 3 && c < 6));
      if (c > 0) begin
        chk("s2_out_valid", 32'(out_valid[3]), 32'h2);
        chk("s2_out_flit", out_flit[3], pf);
        chk("s2_out_last", 32'(out_last[3]), 32'(pl));
      end
      if (c < 3) begin
        pf = 32'h10 + a;
        pl = (a == 2);
        a++;
      end else if (c < 6) begin
        pf = 32'h20 + b;
        pl = (b == 2);
        b++;
      end
      @(posedge clk);
      #1;
    end

    // credit exhaustion: 6-flit packet, input 1 -> output 0 VC0, one return in cycle 4
    reset_dut();
    a = 0;
    for (int c = 0; c < 7; c++) begin
      clear_inputs();
      in_valid[1][0][0] = 1'b1;
      in_flit[1]        = 32'h300 + a;
      in_last[1]        = (a == 5);
      if (c == 4) out_credit[0][0] = 1'b1;
      @(negedge clk);
      chk("s3_ready", 32'(in_ready[1][0][0]), 32'(c < 4 || c == 5));
      if (c == 4) chk("s3_credit_zero", 32'(dut.credit[0][0]), 32'h0);
      if (c > 0) begin
        if ((c - 1) < 4 || (c - 1) == 5) begin
          chk("s3_out_valid", 32'(out_valid[0]), 32'h1);
          chk("s3_out_flit", out_flit[0], pf);
        end else begin
          chk("s3_out_idle", 32'(out_valid[0]), 32'h0);
        end
      end
      pf = 32'h300 + a;
      if (c < 4 || c == 5) a++;
      @(posedge clk);
      #1;
    end

    // VC interleave on output 2: input 0 on VC0, input 1 on VC1, 4 flits each
    reset_dut();
    a = 0;
    b = 0;
    p0 = 1'b0;
    for (int c = 0; c < 9; c++) begin
      clear_inputs();
      if (a < 4) begin
        in_valid[0][0][2] = 1'b1;
        in_flit[0]        = 32'h100 + a;
        in_last[0]        = (a == 3);
      end
      if (b < 4) begin
        in_valid[1][1][2] = 1'b1;
        in_flit[1]        = 32'h200 + b;
        in_last[1]        = (b == 3);
      end
      @(negedge clk);
      chk("s4_ready_vc0", 32'(in_ready[0][0][2]), 32'(c < 8 && (c % 2) == 0));
      chk("s4_ready_vc1", 32'(in_ready[1][1][2]), 32'(c < 8 && (c % 2) == 1));
      if (c > 0) begin
        chk("s4_out_valid", 32'(out_valid[2]), p0 ? 32'h1 : 32'h2);
        chk("s4_out_flit", out_flit[2], pf);
      end
      if (c < 8) begin
        p0 = ((c % 2) == 0);
        if (p0) begin
          pf = 32'h100 + a;
          a++;
        end else begin
          pf = 32'h200 + b;
          b++;
        end
      end
      @(posedge clk);
      #1;
    end

    // credit arithmetic on output 4 VC0
    reset_dut();
    in_valid[4][0][4] = 1'b1;
    in_last[4]        = 1'b1;
    in_flit[4]        = 32'h400;
    @(negedge clk);
    chk("s5_ready_a", 32'(in_ready[4][0][4]), 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("s5_ready_b", 32'(in_ready[4][0][4]), 32'h1);
    @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    chk("s5_credit_two", 32'(dut.credit[4][0]), 32'h2);
    in_valid[4][0][4] = 1'b1;
    in_last[4]        = 1'b1;
    out_credit[4][0]  = 1'b1;
    #1;
    chk("s5_ready_c", 32'(in_ready[4][0][4]), 32'h1);
    @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    chk("s5_simul", 32'(dut.credit[4][0]), 32'h2);
    out_credit[4][0] = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    chk("s5_refill", 32'(dut.credit[4][0]), 32'h4);
    out_credit[4][0] = 1'b1;
    @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    chk("s5_saturate", 32'(dut.credit[4][0]), 32'h4);
    @(posedge clk);
    #1;

    // reset mid-packet: input 0, 5-flit packet to output 1 VC1
    reset_dut();
    a = 0;
    for (int c = 0; c < 2; c++) begin
      in_valid[0][1][1] = 1'b1;
      in_flit[0]        = 32'h500 + a;
      in_last[0]        = 1'b0;
      @(negedge clk);
      chk("s6_ready", 32'(in_ready[0][1][1]), 32'h1);
      a++;
      @(posedge clk);
      #1;
    end
    #1;
    chk("s6_pre_valid", 32'(out_valid[1]), 32'h2);
    chk("s6_pre_lock", 32'(dut.lock_vld[1][1]), 32'h1);
    rst = 1'b0;
    #1;
    chk("s6_async_valid", 32'(out_valid[1]), 32'h0);
    chk("s6_async_credit", 32'(dut.credit[1][1]), 32'(CR));
    chk("s6_ready_in_rst", 32'(in_ready[0][1][1]), 32'h0);
    chk("s6_lock_clr", 32'(dut.lock_vld[1][1]), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    in_valid[3][1][1] = 1'b1;
    in_last[3]        = 1'b1;
    in_flit[3]        = 32'h600;
    #1;
    chk("s6_new_grant", 32'(in_ready[3][1][1]), 32'h1);
    @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    chk("s6_new_valid", 32'(out_valid[1]), 32'h2);
    chk("s6_new_flit", out_flit[1], 32'h600);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
